// File: rtl/operator_slot_sequencer.sv
//------------------------------------------------------------------------------
// operator_slot_sequencer
//   Per-frame time-slot scheduler: walks every bank/operator slot, issuing one
//   slot_valid strobe every CYCLES_PER_SLOT cycles. Optional overrun counter
//   enabled by SEQ_OVERRUN_COUNT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module operator_slot_sequencer #(
   parameter int NUM_BANKS              = 2,
   parameter int NUM_OPERATORS_PER_BANK = 18,
   parameter int CYCLES_PER_SLOT        = 4,
   localparam int c_BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int c_OP_W   = (NUM_OPERATORS_PER_BANK > 1) ? $clog2(NUM_OPERATORS_PER_BANK) : 1,
   localparam int c_CYC_W  = (CYCLES_PER_SLOT > 1) ? $clog2(CYCLES_PER_SLOT) : 1
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_sample_clk_en,
   input  logic                i_enable,
   input  logic                i_overrun_clr,
   output logic                o_slot_valid,
   output logic [c_BANK_W-1:0] o_bank_num,
   output logic [c_OP_W-1:0]   o_op_num,
   output logic                o_slot_first,
   output logic                o_slot_last,
   output logic                o_busy,
   output logic                o_frame_done,
   output logic                o_overrun
`ifdef SEQ_OVERRUN_COUNT_EN
  ,output logic [15:0]         o_overrun_count
`endif
);

   localparam logic [c_BANK_W-1:0] c_BANK_LAST = c_BANK_W'(NUM_BANKS - 1);
   localparam logic [c_OP_W-1:0]   c_OP_LAST   = c_OP_W'(NUM_OPERATORS_PER_BANK - 1);
   localparam logic [c_CYC_W-1:0]  c_CYC_LAST  = c_CYC_W'(CYCLES_PER_SLOT - 1);
   localparam logic                c_ONE_SLOT  = (NUM_BANKS * NUM_OPERATORS_PER_BANK) == 1;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              r_state;
   logic [c_CYC_W-1:0]  r_cyc;
   logic [c_OP_W-1:0]   r_op;
   logic [c_BANK_W-1:0] r_bank;
   logic                r_slot_valid;
   logic                r_first;
   logic                r_last;
   logic                r_frame_done;
   logic                r_overrun;

   state_t              w_state;
   logic [c_CYC_W-1:0]  w_cyc;
   logic [c_OP_W-1:0]   w_op;
   logic [c_BANK_W-1:0] w_bank;
   logic                w_slot_valid;
   logic                w_first;
   logic                w_last;
   logic                w_frame_done;
   logic                w_overrun;
   logic                w_ovr_evt;

   always_comb begin
      w_state      = r_state;
      w_cyc        = r_cyc;
      w_op         = r_op;
      w_bank       = r_bank;
      w_slot_valid = 1'b0;
      w_first      = 1'b0;
      w_last       = 1'b0;
      w_frame_done = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_sample_clk_en && i_enable) begin
               w_state      = S_RUN;
               w_cyc        = '0;
               w_op         = '0;
               w_bank       = '0;
               w_slot_valid = 1'b1;
               w_first      = 1'b1;
               w_last       = c_ONE_SLOT;
            end
         end
         S_RUN: begin
            if (r_cyc == c_CYC_LAST) begin
               w_cyc = '0;
               if ((r_op == c_OP_LAST) && (r_bank == c_BANK_LAST)) begin
                  // Last slot's final cycle: park counters at zero for the idle phase.
                  w_state      = S_IDLE;
                  w_op         = '0;
                  w_bank       = '0;
                  w_frame_done = 1'b1;
               end else begin
                  if (r_op == c_OP_LAST) begin
                     w_op   = '0;
                     w_bank = r_bank + c_BANK_W'(1);
                  end else begin
                     w_op   = r_op + c_OP_W'(1);
                  end
                  w_slot_valid = 1'b1;
                  w_last       = (w_op == c_OP_LAST) && (w_bank == c_BANK_LAST);
               end
            end else begin
               w_cyc = r_cyc + c_CYC_W'(1);
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // A start request while a frame is running is an overrun; set beats clear.
   assign w_ovr_evt = i_sample_clk_en && (r_state == S_RUN);

   always_comb begin
      w_overrun = r_overrun;
      if (w_ovr_evt) begin
         w_overrun = 1'b1;
      end else if (i_overrun_clr) begin
         w_overrun = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_cyc        <= '0;
         r_op         <= '0;
         r_bank       <= '0;
         r_slot_valid <= 1'b0;
         r_first      <= 1'b0;
         r_last       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_cyc        <= w_cyc;
         r_op         <= w_op;
         r_bank       <= w_bank;
         r_slot_valid <= w_slot_valid;
         r_first      <= w_first;
         r_last       <= w_last;
         r_frame_done <= w_frame_done;
         r_overrun    <= w_overrun;
      end
   end

`ifdef SEQ_OVERRUN_COUNT_EN
   logic [15:0] r_ovr_cnt;
   logic [15:0] w_ovr_cnt;

   always_comb begin
      w_ovr_cnt = r_ovr_cnt;
      if (w_ovr_evt) begin
         if (i_overrun_clr) begin
            w_ovr_cnt = 16'd1;
         end else if (r_ovr_cnt != 16'hFFFF) begin
            w_ovr_cnt = r_ovr_cnt + 16'd1;
         end
      end else if (i_overrun_clr) begin
         w_ovr_cnt = 16'd0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ovr_cnt <= 16'd0;
      end else begin
         r_ovr_cnt <= w_ovr_cnt;
      end
   end

   assign o_overrun_count = r_ovr_cnt;
`endif

   assign o_slot_valid = r_slot_valid;
   assign o_bank_num   = r_bank;
   assign o_op_num     = r_op;
   assign o_slot_first = r_first;
   assign o_slot_last  = r_last;
   assign o_busy       = (r_state == S_RUN);
   assign o_frame_done = r_frame_done;
   assign o_overrun    = r_overrun;

endmodule

`default_nettype wire
